// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR scheduler: legal parameter ranges, FSM
// states and the per-width feedback tap masks.
package lfsr_pkg;

  localparam int N_MIN     = 3;
  localparam int N_MAX     = 8;
  localparam int R_MIN     = 2;
  localparam int R_MAX     = 8;
  localparam int STEPS_MIN = 1;
  localparam int STEPS_MAX = 15;

  typedef enum logic {
    IDLE = 1'b0,
    ADV  = 1'b1
  } state_t;

  // Maximal-length tap positions; bit i set means q[i] feeds the XOR.
  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return 8'b0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// N-bit Fibonacci LFSR register with load, single-step and optional
// all-zero recovery (recover tied low when recovery is not built in).
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step,
  input  logic         recover,
  output logic [N-1:0] q
);

  localparam logic [7:0]   TAPS_FULL = tap_mask(N);
  localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("lfsr_core: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
  end

  logic feedback;
  assign feedback = ^(q & TAPS);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= ONE;
    end else if (load) begin
      q <= (recover && load_val == '0) ? ONE : load_val;
    end else if (step) begin
      q <= (recover && q == '0) ? ONE : {q[N-2:0], feedback};
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin time-sharing of one LFSR between R requesters; each grant
// delivers one value, then the LFSR advances STEPS shifts before the next.
// Define LFSR_SCHED_LOCKUP_EN to build in all-zero seed/state recovery.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int N     = 4,
  parameter int R     = 4,
  parameter int STEPS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_we,
  input  logic [N-1:0] seed,
  input  logic [R-1:0] req,
  output logic [R-1:0] gnt,
  output logic [N-1:0] rnd,
  output logic         rnd_valid,
  output logic         busy
);

  localparam int         PW       = $clog2(R);
  localparam logic [3:0] CNT_INIT = 4'(STEPS - 1);

  if (R < R_MIN || R > R_MAX) begin : g_bad_r
    $error("lfsr_sched: R=%0d outside legal range %0d..%0d", R, R_MIN, R_MAX);
  end
  if (STEPS < STEPS_MIN || STEPS > STEPS_MAX) begin : g_bad_steps
    $error("lfsr_sched: STEPS=%0d outside legal range %0d..%0d", STEPS, STEPS_MIN, STEPS_MAX);
  end

  state_t        state;
  logic [PW-1:0] ptr;
  logic [3:0]    cnt;
  logic [N-1:0]  q;
  logic          recover;

`ifdef LFSR_SCHED_LOCKUP_EN
  assign recover = 1'b1;
`else
  assign recover = 1'b0;
`endif

  // Winner: first asserted request at or after the priority pointer, wrapping.
  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] win_next;
  int            idx;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < R; i++) begin
      idx = (int'(ptr) + i) % R;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_next = (win == PW'(R - 1)) ? '0 : win + 1'b1;

  logic do_step;
  assign do_step = !seed_we && ((state == IDLE && found) || state == ADV);

  lfsr_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_we),
    .load_val (seed),
    .step     (do_step),
    .recover  (recover),
    .q        (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_we) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              gnt       <= {{(R-1){1'b0}}, 1'b1} << win;
              rnd       <= q;
              rnd_valid <= 1'b1;
              ptr       <= win_next;
              if (STEPS > 1) begin
                state <= ADV;
                cnt   <= CNT_INIT;
                busy  <= 1'b1;
              end
            end
          end
          ADV: begin
            // Leave on the edge that performs the final shift.
            if (cnt == 4'd1) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
